// File: rtl/arb_defs.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding and default sizing.
package arb_defs;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01,
        StGap   = 2'b10
    } arb_state_e;

    localparam int unsigned DefN       = 4;
    localparam int unsigned DefSw      = 2;
    localparam int unsigned DefCw      = 4;
    localparam int unsigned DefMaxHold = 12;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping modulo N.
module rr_pick
    import arb_defs::*;
#(
    parameter int unsigned N  = DefN,
    parameter int unsigned SW = DefSw
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          valid,
    output logic [SW-1:0] index
);

    always_comb begin
        int unsigned idx;
        valid = 1'b0;
        index = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid && req[idx]) begin
                valid = 1'b1;
                index = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for a shared mux/bus: registered one-hot grant and select,
// release on DONE, withdrawal or hold timeout, then a one-cycle turnaround gap.
module rr_bus_arbiter
    import arb_defs::*;
#(
    parameter int unsigned N        = DefN,
    parameter int unsigned SW       = DefSw,
    parameter int unsigned CW       = DefCw,
    parameter int unsigned MAX_HOLD = DefMaxHold
) (
    input  logic          clk,
    input  logic          clrb,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] sel,
    output logic          busy,
    output logic          timeout
);

    localparam logic [SW-1:0] LastIdx   = SW'(N - 1);
    localparam logic [CW-1:0] HoldLast  = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] CntMax    = {CW{1'b1}};
    localparam bit            TimeoutEn = (MAX_HOLD != 0);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;

    logic          pick_valid;
    logic [SW-1:0] pick_index;
    logic          hold_expired;
    logic          owner_req;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_index)
    );

    assign owner_req    = req[sel_q];
    assign hold_expired = TimeoutEn && (cnt_q == HoldLast);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d             = '0;
                    gnt_d[pick_index] = 1'b1;
                    sel_d             = pick_index;
                    busy_d            = 1'b1;
                    cnt_d             = '0;
                    state_d           = StGrant;
                end
            end
            StGrant: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done || !owner_req || hold_expired) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = (sel_q == LastIdx) ? '0 : sel_q + 1'b1;
                    // DONE and withdrawal take precedence over a coincident timeout
                    timeout_d = !done && owner_req && hold_expired;
                    state_d   = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
